counter_checker: RTL and testbench

Self-checking monitor placed directly downstream of the Counter DUT in the simulation top. It samples the DUT's enb, count and carryout every cycle and compares them against an internal reference model. It counts wrap-arounds and errors, and raises done/pass so the test scenario can end the run on a verdict rather than on the first carryout.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_checker_sat_counter.sv | 26 ++
 rtl/counter_checker.sv | 107 ++++++++++
 tb/tb_counter_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter checker.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [63:0] max_count(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Up-counter that sticks at LIMIT instead of wrapping.
module sat_counter #(
  parameter int             W     = 8,
  parameter logic [W-1:0]   LIMIT = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != LIMIT)) value_d = value_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/counter_checker.sv
// Monitors a free-running counter against a reference model, tallies
// discrepancies and wraps, and reports a verdict after NUM_WRAPS carryouts.
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_WRAPS = 2,
  parameter int ERR_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enb,
  input  logic [WIDTH-1:0]                 count,
  input  logic                             carryout,
  output logic                             done,
  output logic                             pass,
  output logic                             mismatch,
  output logic [ERR_W-1:0]                 err_count,
  output logic [$clog2(NUM_WRAPS+1)-1:0]   wrap_count
);

  localparam int               WRAP_W  = $clog2(NUM_WRAPS + 1);
  localparam int               WS      = WRAP_W + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(max_count(WIDTH));
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(max_count(ERR_W));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_count_q, exp_count_d;
  logic             mismatch_q, mismatch_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic active, carry_exp, disc, wrap_inc, final_wrap;

  // Compare stage: everything below is registered one cycle after the sample
  always_comb begin
    active     = (state_q != DONE);
    carry_exp  = enb && (exp_count_q == CNT_MAX);
    disc       = active && ((count != exp_count_q) || (carryout != carry_exp));
    wrap_inc   = active && carryout;
    final_wrap = wrap_inc && ((WS'(wrap_count) + WS'(1)) == WS'(NUM_WRAPS));

    state_d     = state_q;
    exp_count_d = exp_count_q;
    mismatch_d  = disc;
    pass_d      = pass_q;

    // Resyncing to the observed count equals exp+enb whenever they agree,
    // and limits a single glitch to a single error.
    if (active) exp_count_d = count + WIDTH'(enb);

    case (state_q)
      IDLE: begin
        if (final_wrap) state_d = DONE;
        else if (enb)   state_d = RUN;
      end
      RUN:     if (final_wrap) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    // The final cycle's own discrepancy must already count against the verdict.
    if (active) pass_d = done_d && (err_count == '0) && !disc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      exp_count_q <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_count_q <= exp_count_d;
      mismatch_q  <= mismatch_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  sat_counter #(
    .W     (ERR_W),
    .LIMIT (ERR_MAX)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (disc),
    .value (err_count)
  );

  sat_counter #(
    .W     (WRAP_W),
    .LIMIT (WRAP_W'(NUM_WRAPS))
  ) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_inc),
    .value (wrap_count)
  );

  assign mismatch = mismatch_q;
  assign done     = done_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed-vector bench for counter_checker with a behavioural reference model.
module tb_counter_checker;

  localparam int WIDTH     = 4;
  localparam int NUM_WRAPS = 2;
  localparam int ERR_W     = 2;
  localparam int CMAX      = (1 << WIDTH) - 1;
  localparam int EMAX      = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enb = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             carryout = 1'b0;
  logic             done, pass, mismatch;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       wrap_count;

  counter_checker #(
    .WIDTH     (WIDTH),
    .NUM_WRAPS (NUM_WRAPS),
    .ERR_W     (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .count      (count),
    .carryout   (carryout),
    .done       (done),
    .pass       (pass),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Reference model state
  int m_exp, m_err, m_wraps;
  bit m_mis, m_done, m_pass;

  // Stimulus-side correct counter value
  int c;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_step();
    bit bad;
    if (rst) begin
      m_exp = 0; m_err = 0; m_wraps = 0;
      m_mis = 0; m_done = 0; m_pass = 0;
    end else if (m_done) begin
      m_mis = 0;
    end else begin
      bad = (int'(count) != m_exp) ||
            (carryout != (enb && (m_exp == CMAX)));
      m_mis = bad;
      if (bad && m_err < EMAX) m_err++;
      if (carryout) m_wraps++;
      m_exp = (int'(count) + int'(enb)) % (CMAX + 1);
      if (m_wraps >= NUM_WRAPS) begin
        m_done = 1;
        m_pass = (m_err == 0);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input int cv, input bit co);
    @(negedge clk);
    rst      = r;
    enb      = e;
    count    = WIDTH'(cv);
    carryout = co;
    @(posedge clk);
    model_step();
  endtask

  task automatic run_good(input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, e, c, e && (c == CMAX));
      c = (c + int'(e)) % (CMAX + 1);
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 0, 1'b0);
    c = 0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("mismatch",   int'(mismatch),   int'(m_mis));
      check("err_count",  int'(err_count),  m_err);
      check("wrap_count", int'(wrap_count), m_wraps);
      check("done",       int'(done),       int'(m_done));
      check("pass",       int'(pass),       int'(m_pass));
    end
  end

  initial begin
    // Reset state
    do_reset();
    do_reset();
    started = 1'b1;
    #1;
    check("rst_done",  int'(done), 0);
    check("rst_pass",  int'(pass), 0);
    check("rst_mis",   int'(mismatch), 0);
    check("rst_err",   int'(err_count), 0);
    check("rst_wrap",  int'(wrap_count), 0);

    // Clean run: carryouts at the 16th and 32nd enabled cycles
    run_good(31, 1'b1);
    #1;
    check("clean_done_early", int'(done), 0);
    check("clean_wrap1",      int'(wrap_count), 1);
    run_good(1, 1'b1);
    #1;
    check("clean_done", int'(done), 1);
    check("clean_pass", int'(pass), 1);
    check("clean_err",  int'(err_count), 0);

    // Count glitch 7 where 5 is expected, then resync
    do_reset();
    run_good(5, 1'b1);
    cyc(1'b0, 1'b1, 7, 1'b0);
    c = 8;
    #1;
    check("glitch_mis", int'(mismatch), 1);
    check("glitch_err", int'(err_count), 1);
    run_good(1, 1'b1);
    #1;
    check("glitch_mis_clr", int'(mismatch), 0);
    run_good(23, 1'b1);
    #1;
    check("glitch_done", int'(done), 1);
    check("glitch_pass", int'(pass), 0);
    check("glitch_err2", int'(err_count), 1);

    // Spurious carryout at count 3 ends the run one wrap early
    do_reset();
    run_good(3, 1'b1);
    cyc(1'b0, 1'b1, 3, 1'b1);
    c = 4;
    #1;
    check("spur_err",  int'(err_count), 1);
    check("spur_wrap", int'(wrap_count), 1);
    run_good(12, 1'b1);
    #1;
    check("spur_done", int'(done), 1);
    check("spur_pass", int'(pass), 0);

    // enb gaps, then carryout while enb=0 at 15
    do_reset();
    run_good(1, 1'b1);
    run_good(2, 1'b0);
    run_good(1, 1'b1);
    #1;
    check("gap_err", int'(err_count), 0);
    run_good(13, 1'b1);
    cyc(1'b0, 1'b0, 15, 1'b1);
    #1;
    check("gapco_err",  int'(err_count), 1);
    check("gapco_wrap", int'(wrap_count), 1);
    check("gapco_mis",  int'(mismatch), 1);
    run_good(1, 1'b1);
    #1;
    check("gapco_done", int'(done), 1);
    check("gapco_pass", int'(pass), 0);

    // Mid-run reset at wrap_count=1, err_count=3
    do_reset();
    run_good(16, 1'b1);
    cyc(1'b0, 1'b1, 9, 1'b0);
    cyc(1'b0, 1'b1, 2, 1'b0);
    cyc(1'b0, 1'b0, 12, 1'b0);
    #1;
    check("pre_rst_err",  int'(err_count), 3);
    check("pre_rst_wrap", int'(wrap_count), 1);
    do_reset();
    #1;
    check("mid_rst_err",  int'(err_count), 0);
    check("mid_rst_wrap", int'(wrap_count), 0);
    check("mid_rst_done", int'(done), 0);
    run_good(32, 1'b1);
    #1;
    check("post_rst_done", int'(done), 1);
    check("post_rst_pass", int'(pass), 1);

    // Stuck count: error counter saturates at 3
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 0, 1'b0);
    #1;
    check("stuck_err", int'(err_count), 3);
    cyc(1'b0, 1'b1, 0, 1'b1);
    cyc(1'b0, 1'b1, 0, 1'b1);
    #1;
    check("stuck_err_sat", int'(err_count), 3);
    check("stuck_done",    int'(done), 1);
    check("stuck_pass",    int'(pass), 0);
    cyc(1'b0, 1'b1, 5, 1'b1);
    #1;
    check("frozen_mis",  int'(mismatch), 0);
    check("frozen_wrap", int'(wrap_count), 2);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
